// File: rtl/phy_tx_ctrl_if.sv
// Requester-side bundle for phy_tx_ctrl: two packet requesters and their grants.
// master = requester side, slave = link controller side.
interface phy_tx_ctrl_if;
    logic        req_0;
    logic [31:0] data_0;
    logic        last_0;
    logic        gnt_0;
    logic        req_1;
    logic [31:0] data_1;
    logic        last_1;
    logic        gnt_1;

    modport master (
        output req_0, data_0, last_0, req_1, data_1, last_1,
        input  gnt_0, gnt_1
    );

    modport slave (
        input  req_0, data_0, last_0, req_1, data_1, last_1,
        output gnt_0, gnt_1
    );
endinterface

// File: rtl/phy_tx_ctrl.sv
// PHY TX link controller: training run after reset, then round-robin whole-packet
// arbitration between two requesters with skip words inserted at packet boundaries.
module phy_tx_ctrl #(
    parameter int unsigned TRAIN_WORDS  = 16,
    parameter int unsigned SKP_INTERVAL = 64,
    parameter logic [7:0]  COM          = 8'hBC,
    parameter logic [7:0]  SKP          = 8'h1C
) (
    input  logic                clk_f,
    input  logic                reset,
    phy_tx_ctrl_if.slave        req_if,
    output logic [31:0]         data_out,
    output logic                valid_out,
    output logic                link_up
);
    localparam int unsigned TCW = $clog2(TRAIN_WORDS + 1);
    localparam int unsigned SCW = $clog2(SKP_INTERVAL + 1);

    typedef enum logic [2:0] {TRAIN, IDLE, PKT0, PKT1, SKIP} state_t;

    state_t          state, state_nxt;
    logic [TCW-1:0]  train_cnt, train_cnt_nxt;
    logic [SCW-1:0]  skp_cnt, skp_cnt_nxt;
    logic            rr, rr_nxt;
    logic [31:0]     data_nxt;
    logic            valid_nxt;
    logic            link_nxt;
    logic            skp_due;

    assign skp_due      = (skp_cnt == SCW'(SKP_INTERVAL));
    assign req_if.gnt_0 = (state == PKT0);
    assign req_if.gnt_1 = (state == PKT1);

    always_comb begin
        state_nxt     = state;
        train_cnt_nxt = train_cnt;
        rr_nxt        = rr;
        data_nxt      = '0;
        valid_nxt     = 1'b0;
        link_nxt      = link_up;
        skp_cnt_nxt   = skp_cnt;
        if (link_up && !skp_due)
            skp_cnt_nxt = skp_cnt + 1'b1;

        case (state)
            TRAIN: begin
                data_nxt      = {4{COM}};
                valid_nxt     = 1'b1;
                train_cnt_nxt = train_cnt + 1'b1;
                if (train_cnt == TCW'(TRAIN_WORDS - 1)) begin
                    state_nxt = IDLE;
                    link_nxt  = 1'b1;
                end
            end
            IDLE: begin
                if (skp_due)
                    state_nxt = SKIP;
                else if (req_if.req_0 && (!req_if.req_1 || !rr))
                    state_nxt = PKT0;
                else if (req_if.req_1)
                    state_nxt = PKT1;
            end
            PKT0: begin
                if (req_if.req_0) begin
                    data_nxt  = req_if.data_0;
                    valid_nxt = 1'b1;
                    if (req_if.last_0) begin
                        rr_nxt    = 1'b1;
                        state_nxt = skp_due ? SKIP : IDLE;
                    end
                end
            end
            PKT1: begin
                if (req_if.req_1) begin
                    data_nxt  = req_if.data_1;
                    valid_nxt = 1'b1;
                    if (req_if.last_1) begin
                        rr_nxt    = 1'b0;
                        state_nxt = skp_due ? SKIP : IDLE;
                    end
                end
            end
            SKIP: begin
                data_nxt    = {COM, SKP, SKP, SKP};
                valid_nxt   = 1'b1;
                skp_cnt_nxt = '0;
                state_nxt   = IDLE;
            end
            default: state_nxt = TRAIN;
        endcase
    end

    always_ff @(posedge clk_f) begin
        if (reset) begin
            state     <= TRAIN;
            train_cnt <= '0;
            skp_cnt   <= '0;
            rr        <= 1'b0;
            data_out  <= '0;
            valid_out <= 1'b0;
            link_up   <= 1'b0;
        end else begin
            state     <= state_nxt;
            train_cnt <= train_cnt_nxt;
            skp_cnt   <= skp_cnt_nxt;
            rr        <= rr_nxt;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
            link_up   <= link_nxt;
        end
    end
endmodule

// File: tb/tb_phy_tx_ctrl.sv
// Self-checking bench for phy_tx_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level model of the link.
module tb_phy_tx_ctrl;
    localparam int unsigned TW = 16;
    localparam int unsigned SI = 8;
    localparam logic [31:0] COMW = 32'hBCBCBCBC;
    localparam logic [31:0] SKPW = 32'hBC1C1C1C;

    logic        clk_f = 1'b0;
    logic        reset;
    logic [31:0] data_out;
    logic        valid_out;
    logic        link_up;

    phy_tx_ctrl_if bus ();

    phy_tx_ctrl #(.TRAIN_WORDS(TW), .SKP_INTERVAL(SI)) dut (
        .clk_f     (clk_f),
        .reset     (reset),
        .req_if    (bus.slave),
        .data_out  (data_out),
        .valid_out (valid_out),
        .link_up   (link_up)
    );

    always #5 clk_f = ~clk_f;

    int checks = 0;
    int errors = 0;

    // Pending packet words per requester (word, last flag).
    logic [31:0] q0[$], q1[$];
    bit          l0[$], l1[$];
    int          drop0 = 0, drop1 = 0;
    bit          force_low0 = 0;

    // Link model: trained word count, link status, skip age, packet owner, preference.
    int          m_trained, m_age, m_own, m_pref;
    bit          m_up, m_skip;
    logic [31:0] e_data;
    bit          e_valid, e_link;
    bit          xfer0, xfer1;

    // Observation tallies for scenario-level checks.
    int com_cnt, g0_cnt, g1_cnt, skp_in_pkt;
    bit prev_g0, prev_g1;
    int gseq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_trained = 0; m_age = 0; m_own = -1; m_pref = 0; m_up = 0; m_skip = 0;
        e_data = '0; e_valid = 0; e_link = 0;
    endfunction

    function automatic void model_step();
        bit due;
        bit rq, lst;
        xfer0 = 0; xfer1 = 0;
        if (reset) begin
            model_reset();
            return;
        end
        due = (m_age == SI);
        if (m_up && !m_skip) m_age = (m_age < SI) ? m_age + 1 : SI;
        if (!m_up) begin
            e_data = COMW; e_valid = 1;
            m_trained++;
            if (m_trained == TW) begin m_up = 1; e_link = 1; end
        end else if (m_skip) begin
            e_data = SKPW; e_valid = 1; m_age = 0; m_skip = 0;
        end else if (m_own >= 0) begin
            rq  = (m_own == 0) ? bus.req_0 : bus.req_1;
            lst = (m_own == 0) ? bus.last_0 : bus.last_1;
            if (rq) begin
                e_data  = (m_own == 0) ? bus.data_0 : bus.data_1;
                e_valid = 1;
                if (m_own == 0) xfer0 = 1; else xfer1 = 1;
                if (lst) begin m_pref = 1 - m_own; m_own = -1; m_skip = due; end
            end else begin
                e_data = '0; e_valid = 0;
            end
        end else begin
            e_data = '0; e_valid = 0;
            if (due) m_skip = 1;
            else if (bus.req_0 && bus.req_1) m_own = m_pref;
            else if (bus.req_0) m_own = 0;
            else if (bus.req_1) m_own = 1;
        end
    endfunction

    task automatic cycle();
        bus.req_0  = (q0.size() > 0) && !force_low0 && ($urandom_range(99) >= drop0);
        bus.data_0 = (q0.size() > 0) ? q0[0] : $urandom;
        bus.last_0 = (q0.size() > 0) ? l0[0] : 1'($urandom);
        bus.req_1  = (q1.size() > 0) && ($urandom_range(99) >= drop1);
        bus.data_1 = (q1.size() > 0) ? q1[0] : $urandom;
        bus.last_1 = (q1.size() > 0) ? l1[0] : 1'($urandom);
        @(negedge clk_f);
        chk("data_out", data_out, e_data);
        chk("valid_out", valid_out, e_valid);
        chk("link_up", link_up, e_link);
        chk("gnt_0", bus.gnt_0, m_up && !m_skip && m_own == 0);
        chk("gnt_1", bus.gnt_1, m_up && !m_skip && m_own == 1);
        if (valid_out && data_out == COMW) com_cnt++;
        if (bus.gnt_0) g0_cnt++;
        if (bus.gnt_1) g1_cnt++;
        if ((bus.gnt_0 || bus.gnt_1) && valid_out && data_out == SKPW) skp_in_pkt++;
        if (bus.gnt_0 && !prev_g0) gseq.push_back(0);
        if (bus.gnt_1 && !prev_g1) gseq.push_back(1);
        prev_g0 = bus.gnt_0; prev_g1 = bus.gnt_1;
        model_step();
        @(posedge clk_f);
        #1;
        if (xfer0) begin void'(q0.pop_front()); void'(l0.pop_front()); end
        if (xfer1) begin void'(q1.pop_front()); void'(l1.pop_front()); end
    endtask

    task automatic load(input int n, input int len, input logic [31:0] base, input bit rnd);
        for (int i = 0; i < len; i++) begin
            logic [31:0] w;
            w = rnd ? $urandom : base * (i + 1);
            if (n == 0) begin q0.push_back(w); l0.push_back(i == len - 1); end
            else        begin q1.push_back(w); l1.push_back(i == len - 1); end
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int c = 0;
        while ((q0.size() > 0 || q1.size() > 0) && c < budget) begin cycle(); c++; end
        chk(tag, q0.size() + q1.size(), 0);
    endtask

    initial begin
        reset = 1;
        bus.req_0 = 0; bus.req_1 = 0; bus.data_0 = '0; bus.data_1 = '0;
        bus.last_0 = 0; bus.last_1 = 0;
        repeat (2) @(posedge clk_f);
        #1;
        model_reset();

        // Reset state, training run, idle until the first skip word.
        cycle();
        reset = 0;
        com_cnt = 0;
        repeat (TW + SI + 4) cycle();
        chk("train_words", com_cnt, TW);

        // Requester 0 alone, 3-word packet.
        g0_cnt = 0; g1_cnt = 0;
        load(0, 3, 32'h11111111, 0);
        repeat (8) cycle();
        chk("pkt3_gnt0_cycles", g0_cnt, 3);
        chk("pkt3_gnt1_cycles", g1_cnt, 0);
        chk("pkt3_drained", q0.size(), 0);

        // Reset mid-packet abandons it and restarts training.
        load(0, 5, 32'h0A0A0A0A, 0);
        repeat (12) cycle();
        reset = 1;
        cycle();
        reset = 0;
        q0.delete(); l0.delete();
        com_cnt = 0;
        repeat (TW + 2) cycle();
        chk("retrain_words", com_cnt, TW);

        // Both requesters, back-to-back 2-word packets: strict alternation from 0.
        gseq.delete();
        for (int p = 0; p < 3; p++) begin
            load(0, 2, 32'h01000000 + p, 0);
            load(1, 2, 32'h02000000 + p, 0);
        end
        drain("alt_drain", 200);
        chk("alt_count", gseq.size(), 6);
        for (int i = 0; i < gseq.size() && i < 6; i++) chk("alt_order", gseq[i], i % 2);

        // Requester 0 stalls for two cycles mid-packet.
        load(0, 6, 32'h00000101, 0);
        for (int c = 0; c < 50 && q0.size() > 4; c++) cycle();
        force_low0 = 1;
        repeat (2) cycle();
        force_low0 = 0;
        drain("stall_drain", 100);

        // Long packet spans skip-counter saturation; skip is deferred to the boundary.
        skp_in_pkt = 0;
        load(1, 20, 32'h00010001, 0);
        drain("long_drain", 100);
        repeat (4) cycle();
        chk("skp_inside_pkt", skp_in_pkt, 0);

        // Randomized traffic with request gaps.
        drop0 = 30; drop1 = 30;
        for (int p = 0; p < 25; p++) begin
            load(0, $urandom_range(6, 1), '0, 1);
            load(1, $urandom_range(6, 1), '0, 1);
        end
        drain("rand_drain", 3000);
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/phy_tx_ctrl.md
# phy_tx_ctrl

Transmit-side link controller that sequences and feeds the 32-bit parallel input of the two-lane PHY TX datapath. After reset it emits a fixed run of training words, then arbitrates packet-by-packet between two requesters (round-robin, whole-packet grants). It periodically inserts a skip ordered-set word at packet boundaries. Its `data_out`/`valid_out` connect directly to the PHY TX `data_in`/`valid_in`; it runs on the word clock `clk_f`.

## Interface
- `TRAIN_WORDS`, 16: number of training words sent after reset; must be ≥1.
- `SKP_INTERVAL`, 64: minimum cycles between skip words; must be ≥2.
- `COM`, 8'hBC: comma symbol.
- `SKP`, 8'h1C: skip symbol.

- `clk_f`  in  1  word clock; the only clock. Everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_0`  in  1  requester 0 has a word presented this cycle.
- `data_0`  in  32  requester 0 word.
- `last_0`  in  1  the presented word is the final word of a packet.
- `gnt_0`  out  1  requester 0 owns the link. A word transfers on any cycle with `req_0 && gnt_0`.
- `req_1`, `data_1`, `last_1`, `gnt_1`: same as above, for requester 1.
- `data_out`  out  32  word to PHY TX; registered.
- `valid_out`  out  1  `data_out` is valid; registered.
- `link_up`  out  1  training complete; registered.

## Operation
- States are TRAIN, IDLE, PKT0, PKT1 and SKIP.
- Reset forces the following values:
  - state = TRAIN; train counter = 0; skip counter = 0; RR pointer = 0 (requester 0 preferred).
  - `data_out` = 0, `valid_out` = 0, `link_up` = 0.
- Reset asserted mid-packet abandons the packet; no further words from that packet are accepted.
- TRAIN:
  - Each cycle emits {COM,COM,COM,COM} (32'hBCBCBCBC), valid.
  - After exactly TRAIN_WORDS words, go to IDLE and set `link_up` = 1.
  - Both grants stay 0.
- IDLE:
  - Emits `data_out` = 0, `valid_out` = 0; grants are 0.
  - Priority order: if `skp_due`, go to SKIP. Otherwise, if only one `req_n` is high, go to PKTn. If both are high, go to the PKT state of the requester the RR pointer selects.
- PKTn:
  - `gnt_n` = 1 (combinational from state only); the other grant is 0.
  - On a transfer, the next cycle has `data_out` = `data_n` and `valid_out` = 1.
  - If `req_n` is low, the next cycle has `valid_out` = 0, `data_out` = 0, and the state is held. There is no timeout.
  - On a transfer with `last_n` = 1:
    - the RR pointer moves to the other requester;
    - the next state is SKIP if `skp_due`, else IDLE.
  - `req` and `data` of the non-granted requester are ignored.
- SKIP:
  - For one cycle, emits {COM,SKP,SKP,SKP} (32'hBC1C1C1C), valid.
  - Clears the skip counter, then goes to IDLE.
- Skip counter:
  - Increments every cycle while `link_up` = 1 and the state is not SKIP.
  - Saturates at SKP_INTERVAL.
  - `skp_due` = (counter == SKP_INTERVAL).
  - A skip word is never inserted inside a packet. When the interval expires mid-packet, the skip is deferred until after the last word.
- Single-word packet: `last_n` = 1 on the first transfer. The state returns to IDLE or SKIP after one PKT cycle.

## Timing
- Data latency from transfer cycle to `data_out`/`valid_out` is exactly 1 cycle.
- Grant latency: a request seen in IDLE at cycle t gives `gnt` = 1 at t+1.
- Packet overhead is exactly one bubble cycle (IDLE) between consecutive packets, plus one cycle when a SKIP word is inserted.
- Sequence after reset deasserts:
  - the first training word appears on `data_out` at the edge after the first non-reset cycle;
  - `link_up` rises on the same edge on which the state enters IDLE.
- Both requesters held continuously with back-to-back packets produce strictly alternating packets 0, 1, 0, 1, …
- Simultaneous `skp_due` and pending requests in IDLE: the SKIP word is sent first.

## Test plan
- Reset, TRAIN_WORDS = 16, no requests:
  - 16 consecutive valid words of 32'hBCBCBCBC;
  - `link_up` = 1 starting at the 17th cycle;
  - `valid_out` then stays 0 until the first SKIP word, which appears once the counter has counted SKP_INTERVAL cycles.
- Requester 0 only, 3-word packet 32'h11111111, 22222222, 33333333 (last on the third word):
  - `gnt_0` is high for 3 cycles;
  - the same three words appear on `data_out` one cycle after each transfer;
  - a one-cycle bubble follows; `gnt_1` never rises.
- Both requesters continuously request 2-word packets: grants alternate starting with 0 (0, 1, 0, 1); no word from the non-granted requester appears on `data_out`.
- SKP_INTERVAL = 8 and a 20-word packet in flight when the counter saturates:
  - no 32'hBC1C1C1C appears inside the packet;
  - exactly one appears on the cycle after the last data word, with the state then going through SKIP to IDLE.
- `req_0` dropped for 2 cycles mid-packet: 2 cycles with `valid_out` = 0, `gnt_0` held high, then the packet resumes with word order intact.
- Reset asserted mid-packet:
  - the next cycle has `valid_out` = 0, `link_up` = 0, and `gnt_0` = 0;
  - the full 16-word training sequence then restarts.
